// File: rtl/priority_encoder_83_pkg.sv
// Shared constants and helpers for the registered 8-to-3 priority encoder.
// Imported by both the combinational search and the registered top.
package priority_encoder_83_pkg;

    localparam int IN_W_DEFAULT = 8;

    // Ceiling log2, kept local so the index width derives the same way in every file.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/priority_encoder_83_search.sv
// Purely combinational highest-set-bit search over the request vector.
// any_set distinguishes "bit 0 wins" from "nothing requested".
module priority_search_comb
    import priority_encoder_83_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int OUT_W = clog2(IN_W)
) (
    input  logic [IN_W-1:0]  inp,
    output logic [OUT_W-1:0] idx,
    output logic             any_set
);

    // Walking upward lets each higher set bit overwrite a lower one, so the MSB wins.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (inp[i]) begin
                idx     = OUT_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_83.sv
// Registered priority encoder: enable-gated search result captured into
// output registers that clear asynchronously on rst_n.
module priority_encoder_83
    import priority_encoder_83_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEFAULT,
    localparam int OUT_W = clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  inp,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] search_idx;
    logic             search_any;
    logic [OUT_W-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    priority_search_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_search (
        .inp     (inp),
        .idx     (search_idx),
        .any_set (search_any)
    );

    // Gating on en keeps an undriven request bus from leaking into the registers.
    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        if (en && search_any) begin
            out_d   = search_idx;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_83.sv
// Scoreboard bench for priority_encoder_83: the driver queues hand-computed
// {valid,out} expectations, a monitor pops one after each sampling edge.
module tb_priority_encoder_83;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] inp;
    logic [2:0] out;
    logic       valid;

    logic [3:0] expQ[$];
    string      nameQ[$];
    int         checks;
    int         passes;

    priority_encoder_83 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inp   (inp),
        .out   (out),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan from the top bit down and stop at the first one found.
    function automatic logic [2:0] refIdx(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i] === 1'b1) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] expected);
        checks++;
        if ({valid, out} === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got valid=%b out=%b, expected valid=%b out=%b",
                     name, valid, out, expected[3], expected[2:0]);
        end
    endtask

    // Inputs change on the falling edge; the matching expectation is due after the next rising edge.
    task automatic applyStimulus(input logic e, input logic [7:0] v,
                                 input logic [2:0] expOut, input logic expValid,
                                 input string name);
        @(negedge clk);
        en  = e;
        inp = v;
        expQ.push_back({expValid, expOut});
        nameQ.push_back(name);
    endtask

    // Monitor: every registered update is compared against the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        inp    = 8'h00;

        #1;
        checkOutput("reset_initial", 4'b0_000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 8'h80, 3'd7, 1'b1, "pre_reset_80");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", 4'b0_000);
        @(posedge clk);
        #2;
        checkOutput("reset_held", 4'b0_000);
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back({1'b1, 3'd7});
        nameQ.push_back("post_release_80");

        applyStimulus(1'b1, 8'd128, 3'd7, 1'b1, "onehot_128");
        applyStimulus(1'b1, 8'd64,  3'd6, 1'b1, "onehot_64");
        applyStimulus(1'b1, 8'd32,  3'd5, 1'b1, "onehot_32");
        applyStimulus(1'b1, 8'd16,  3'd4, 1'b1, "onehot_16");

        applyStimulus(1'b1, 8'h09, 3'd3, 1'b1, "multi_09");
        applyStimulus(1'b1, 8'hFF, 3'd7, 1'b1, "multi_FF");
        applyStimulus(1'b1, 8'h03, 3'd1, 1'b1, "multi_03");

        applyStimulus(1'b1, 8'h00, 3'd0, 1'b0, "zero");
        applyStimulus(1'b1, 8'h01, 3'd0, 1'b1, "lsb_only");

        applyStimulus(1'b0, 8'bxxxx_xxxx, 3'd0, 1'b0, "disabled_x");
        applyStimulus(1'b0, 8'hFF, 3'd0, 1'b0, "disabled_FF");
        applyStimulus(1'b1, 8'h40, 3'd6, 1'b1, "reenable_40");

        for (int v = 0; v < 256; v++) begin
            applyStimulus(1'b1, 8'(v), refIdx(8'(v)), (v != 0),
                          $sformatf("exhaustive_%02h", v));
        end

        @(posedge clk);
        #4;
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
